// File: rtl/sensor_trace_pkg.sv
// Shared types and helpers for the sensor trace buffer and its sample RAM.
package sensor_trace_pkg;

  typedef enum logic [2:0] {StIdle, StArmed, StCapture, StDump, StHold} state_e;

  // Origin of the byte fetched into the dump pipeline.
  typedef enum logic [1:0] {SrcHdr, SrcChan, SrcRam, SrcZero} src_e;

  localparam logic [7:0] HEADER_BYTE = 8'hA5;

  function automatic int unsigned addr_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port DEPTH x 8 sample store with a registered read port.
module trace_ram
  import sensor_trace_pkg::*;
#(
  parameter int unsigned DEPTH = 2048,
  localparam int unsigned AW = addr_w(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/sensor_trace_buffer.sv
// Arm/trigger capture of one sensor channel into trace_ram, then a handshaked byte dump.
// Define TRACE_PRETRIGGER_EN to also keep PRE samples from before the trigger.
module sensor_trace_buffer
  import sensor_trace_pkg::*;
#(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned SAMPLE_W  = 8,
  parameter int unsigned DEPTH     = 2048,
  parameter int unsigned PRE       = 512,
  parameter logic [7:0]  MARK_CODE = 8'hFF,
  parameter int unsigned HOLDOFF   = 4096,
  localparam int unsigned CW = addr_w(CHANNELS)
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [CHANNELS*SAMPLE_W-1:0] samples_i,
  input  logic [CW-1:0]                ch_sel,
  input  logic                         arm,
  input  logic                         trig,
  input  logic                         mark,
  output logic [7:0]                   tx_data,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic                         busy,
  output logic                         done
);

  localparam int unsigned AW = addr_w(DEPTH);
  localparam int unsigned HW = addr_w(HOLDOFF);
`ifdef TRACE_PRETRIGGER_EN
  localparam int unsigned CapN = DEPTH - PRE;
  localparam logic [AW:0] PreL = (AW+1)'(PRE);
`else
  localparam int unsigned CapN = DEPTH;
`endif
  localparam logic [AW:0]   CapLast  = (AW+1)'(CapN - 1);
  localparam logic [AW:0]   FetchEnd = (AW+1)'(DEPTH + 2);
  localparam logic [HW-1:0] HoldLast = HW'(HOLDOFF - 1);

  if (PRE >= DEPTH || DEPTH < 16) begin : g_bad_cfg
    $error("sensor_trace_buffer: need 16 <= DEPTH and PRE < DEPTH");
  end

  state_e        state_q, state_d;
  logic [CW-1:0] ch_q, ch_d, ch_eff;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, fetch_j;
  logic [AW:0]   cap_cnt_q, cap_cnt_d, fetch_q, fetch_d;
  logic          pend_q, pend_d, pf_valid_q, pf_valid_d;
  src_e          src_q, src_d, fetch_src;
  logic [7:0]    pf_q, pf_d, tx_data_q, tx_data_d, in_data, wr_data, rdata;
  logic          tx_valid_q, tx_valid_d, busy_q, busy_d, done_q, done_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [SAMPLE_W-1:0] smp;
  logic          we, take, issue;
  logic [1:0]    held;
`ifdef TRACE_PRETRIGGER_EN
  logic [AW:0]   pre_fill_q, pre_fill_d;
`endif

  assign ch_eff  = ({1'b0, ch_sel} < (CW+1)'(CHANNELS)) ? ch_sel : '0;
  assign wr_data = mark ? MARK_CODE : 8'(smp);
  assign fetch_j = fetch_q[AW-1:0] - AW'(2);
  assign take    = tx_valid_q & tx_ready;
  // Bytes still held after this cycle; a new fetch only issues if it will have a slot.
  assign held    = 2'(tx_valid_q) + 2'(pf_valid_q) + 2'(pend_q) - 2'(take);
  assign issue   = (state_q == StDump) && (fetch_q != FetchEnd) && (held < 2'd2);

  always_comb begin
    smp = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (ch_q == CW'(c)) smp = samples_i[c*SAMPLE_W +: SAMPLE_W];
    end
  end

  always_comb begin
    fetch_src = SrcRam;
    if (fetch_q == '0) fetch_src = SrcHdr;
    else if (fetch_q == (AW+1)'(1)) fetch_src = SrcChan;
`ifdef TRACE_PRETRIGGER_EN
    else if ((AW+1)'(fetch_j) + pre_fill_q < PreL) fetch_src = SrcZero;
`endif
  end

  always_comb begin
    in_data = 8'h00;
    case (src_q)
      SrcHdr:  in_data = HEADER_BYTE;
      SrcChan: in_data = 8'(ch_q);
      SrcRam:  in_data = rdata;
      default: in_data = 8'h00;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    wr_ptr_d   = wr_ptr_q;
    cap_cnt_d  = cap_cnt_q;
    fetch_d    = fetch_q;
    pend_d     = 1'b0;
    src_d      = src_q;
    pf_d       = pf_q;
    pf_valid_d = pf_valid_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    hold_d     = hold_q;
    done_d     = 1'b0;
    we         = 1'b0;
`ifdef TRACE_PRETRIGGER_EN
    pre_fill_d = pre_fill_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (arm) begin
          state_d   = StArmed;
          ch_d      = ch_eff;
          wr_ptr_d  = '0;
          cap_cnt_d = '0;
`ifdef TRACE_PRETRIGGER_EN
          pre_fill_d = '0;
`endif
        end
      end
      StArmed: begin
`ifdef TRACE_PRETRIGGER_EN
        we = 1'b1;
        if (!trig && pre_fill_q != PreL) pre_fill_d = pre_fill_q + (AW+1)'(1);
`else
        we = trig;
`endif
        if (trig) begin
          cap_cnt_d = (AW+1)'(1);
          fetch_d   = '0;
          state_d   = (CapN == 1) ? StDump : StCapture;
        end
      end
      StCapture: begin
        we        = 1'b1;
        cap_cnt_d = cap_cnt_q + (AW+1)'(1);
        if (cap_cnt_q == CapLast) begin
          state_d = StDump;
          fetch_d = '0;
        end
      end
      StDump: begin
        if (issue) begin
          fetch_d = fetch_q + (AW+1)'(1);
          pend_d  = 1'b1;
          src_d   = fetch_src;
        end
        // Output slot refills from the prefetch byte first to keep byte order.
        if (!tx_valid_q || take) begin
          if (pf_valid_q) begin
            tx_data_d  = pf_q;
            tx_valid_d = 1'b1;
            pf_valid_d = pend_q;
            pf_d       = in_data;
          end else if (pend_q) begin
            tx_data_d  = in_data;
            tx_valid_d = 1'b1;
          end else begin
            tx_valid_d = 1'b0;
          end
        end else if (pend_q) begin
          pf_d       = in_data;
          pf_valid_d = 1'b1;
        end
        if (fetch_q == FetchEnd && !pend_q && !pf_valid_q && take) begin
          state_d = StHold;
          hold_d  = '0;
        end
      end
      StHold: begin
        hold_d = hold_q + HW'(1);
        if (hold_q == HoldLast) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (we) wr_ptr_d = wr_ptr_q + AW'(1);
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      ch_q       <= '0;
      wr_ptr_q   <= '0;
      cap_cnt_q  <= '0;
      fetch_q    <= '0;
      pend_q     <= 1'b0;
      src_q      <= SrcHdr;
      pf_q       <= '0;
      pf_valid_q <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      hold_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef TRACE_PRETRIGGER_EN
      pre_fill_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      wr_ptr_q   <= wr_ptr_d;
      cap_cnt_q  <= cap_cnt_d;
      fetch_q    <= fetch_d;
      pend_q     <= pend_d;
      src_q      <= src_d;
      pf_q       <= pf_d;
      pf_valid_q <= pf_valid_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      hold_q     <= hold_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef TRACE_PRETRIGGER_EN
      pre_fill_q <= pre_fill_d;
`endif
    end
  end

  trace_ram #(
    .DEPTH(DEPTH)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (we),
    .waddr_i(wr_ptr_q),
    .wdata_i(wr_data),
    .raddr_i(wr_ptr_q + fetch_j),
    .rdata_o(rdata)
  );

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_sensor_trace_buffer.sv
// Scoreboard bench for sensor_trace_buffer (DEPTH=16, 3 channels, short holdoff).
module tb_sensor_trace_buffer;

  localparam int CH   = 3;
  localparam int SW   = 8;
  localparam int DEP  = 16;
  localparam int PREN = 4;
  localparam int HOLD = 20;

  logic          clk = 1'b0;
  logic          rstn;
  logic [CH*SW-1:0] samples_i;
  logic [1:0]    ch_sel;
  logic          arm, trig, mark, tx_ready;
  logic [7:0]    tx_data;
  logic          tx_valid, busy, done;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int stall_viol = 0;

  always #5 clk = ~clk;

  sensor_trace_buffer #(
    .CHANNELS (CH),
    .SAMPLE_W (SW),
    .DEPTH    (DEP),
    .PRE      (PREN),
    .MARK_CODE(8'hFF),
    .HOLDOFF  (HOLD)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .samples_i(samples_i),
    .ch_sel   (ch_sel),
    .arm      (arm),
    .trig     (trig),
    .mark     (mark),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .done     (done)
  );

  // Channel 2 carries the plain ramp; channels 1 and 0 are offset so a wrong select shows.
  function automatic logic [CH*SW-1:0] pack(input int v);
    logic [7:0] b;
    b = 8'(v);
    return {b, b + 8'h40, b + 8'h80};
  endfunction

  function automatic logic [7:0] chan_byte(input int c, input int v);
    logic [7:0] b;
    b = 8'(v);
    if (c == 2) return b;
    if (c == 1) return b + 8'h40;
    return b + 8'h80;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic [1:0] sel, input logic with_trig);
    arm = 1'b1;
    trig = with_trig;
    ch_sel = sel;
    tick();
    arm = 1'b0;
    trig = 1'b0;
  endtask

  // Drives DEP capture cycles (trig on the first) and queues the expected dump.
  task automatic do_capture(input int c, input logic [7:0] hdr, input int mlo, input int mhi);
    exp_q.push_back(8'hA5);
    exp_q.push_back(hdr);
    for (int i = 0; i < DEP; i++) begin
      trig = (i == 0);
      mark = (i >= mlo && i <= mhi);
      samples_i = pack(i);
      exp_q.push_back(mark ? 8'hFF : chan_byte(c, i));
      tick();
    end
    trig = 1'b0;
    mark = 1'b0;
  endtask

  task automatic drain(input int n, input logic toggle);
    logic stalled = 1'b0;
    logic [7:0] held_byte = 8'h00;
    for (int c = 0; c < 400 && rx_q.size() < n; c++) begin
      tx_ready = toggle ? c[0] : 1'b1;
      @(negedge clk);
      if (stalled && (!tx_valid || tx_data !== held_byte)) stall_viol++;
      stalled = tx_valid && !tx_ready;
      held_byte = tx_data;
      if (tx_valid && tx_ready) rx_q.push_back(tx_data);
      @(posedge clk);
      #1;
    end
    tx_ready = 1'b1;
  endtask

  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int k = 1; k <= 4 * HOLD; k++) begin
      @(negedge clk);
      if (done) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    arm = 1'b0; trig = 1'b0; mark = 1'b0; tx_ready = 1'b1;
    ch_sel = 2'd0; samples_i = '0;
    #12;
    n_checks++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_tx: valid=%b data=%h, required 0/00", tx_valid, tx_data);
    end
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_status: busy=%b done=%b, required 0/0", busy, done);
    end
    @(posedge clk);
    #1;
    rstn = 1'b1;
    tick();
  endtask

`ifndef TRACE_PRETRIGGER_EN
  task automatic test_basic();
    int cyc;
    logic [7:0] e, a;
    do_arm(2'd2, 1'b0);
    repeat (2) tick();
    n_checks++;
    if (busy !== 1'b1 || tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_armed: busy=%b valid=%b, required 1/0", busy, tx_valid);
    end
    do_capture(2, 8'h02, -1, -1);
    drain(DEP + 2, 1'b0);
    n_checks++;
    if (rx_q.size() != DEP + 2) begin
      n_fail++;
      $display("FAIL basic_count: got %0d bytes, required %0d", rx_q.size(), DEP + 2);
    end
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      if (rx_q.size() > 0) a = rx_q.pop_front(); else a = 'x;
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL basic_byte%0d: got %h, required %h", i, a, e);
      end
    end
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_hold_busy: busy=%b, required 1", busy);
    end
    wait_done(cyc);
    // HOLD occupies HOLDOFF cycles; done is high in the cycle after them.
    n_checks++;
    if (cyc != HOLD + 1) begin
      n_fail++;
      $display("FAIL basic_done_time: done after %0d cycles, required %0d", cyc, HOLD + 1);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done_pulse: done=%b busy=%b, required 0/0", done, busy);
    end
  endtask

  task automatic test_mark();
    int cyc;
    logic [7:0] e, a;
    do_arm(2'd1, 1'b0);
    tick();
    do_capture(1, 8'h01, 4, 5);
    drain(DEP + 2, 1'b0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      if (rx_q.size() > 0) a = rx_q.pop_front(); else a = 'x;
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL mark_byte%0d: got %h, required %h", i, a, e);
      end
    end
    wait_done(cyc);
    n_checks++;
    if (cyc < 0) begin
      n_fail++;
      $display("FAIL mark_done: no done pulse, required one");
    end
  endtask

  // Out-of-range channel 3 falls back to channel 0, dumped under a stalling sink.
  task automatic test_stall();
    int cyc;
    logic [7:0] e, a;
    do_arm(2'd3, 1'b0);
    tick();
    do_capture(0, 8'h00, -1, -1);
    stall_viol = 0;
    drain(DEP + 2, 1'b1);
    n_checks++;
    if (rx_q.size() != DEP + 2) begin
      n_fail++;
      $display("FAIL stall_count: got %0d bytes, required %0d", rx_q.size(), DEP + 2);
    end
    n_checks++;
    if (stall_viol != 0) begin
      n_fail++;
      $display("FAIL stall_stable: %0d unstable stalls, required 0", stall_viol);
    end
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      if (rx_q.size() > 0) a = rx_q.pop_front(); else a = 'x;
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL stall_byte%0d: got %h, required %h", i, a, e);
      end
    end
    wait_done(cyc);
    n_checks++;
    if (cyc < 0) begin
      n_fail++;
      $display("FAIL stall_done: no done pulse, required one");
    end
  endtask

  task automatic test_reset_mid_dump();
    int cyc;
    logic [7:0] e, a;
    do_arm(2'd2, 1'b0);
    tick();
    do_capture(2, 8'h02, -1, -1);
    drain(9, 1'b0);
    for (int i = 0; i < 9; i++) begin
      e = exp_q.pop_front();
      if (rx_q.size() > 0) a = rx_q.pop_front(); else a = 'x;
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL rstdump_byte%0d: got %h, required %h", i, a, e);
      end
    end
    #2 rstn = 1'b0;
    #1;
    n_checks++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL rstdump_async: valid=%b data=%h busy=%b done=%b, required all 0",
               tx_valid, tx_data, busy, done);
    end
    exp_q.delete();
    rx_q.delete();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    tick();
    do_arm(2'd1, 1'b0);
    tick();
    do_capture(1, 8'h01, -1, -1);
    drain(DEP + 2, 1'b0);
    n_checks++;
    if (rx_q.size() != DEP + 2) begin
      n_fail++;
      $display("FAIL rstdump_fresh_count: got %0d bytes, required %0d", rx_q.size(), DEP + 2);
    end
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      if (rx_q.size() > 0) a = rx_q.pop_front(); else a = 'x;
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL rstdump_fresh%0d: got %h, required %h", i, a, e);
      end
    end
    wait_done(cyc);
    n_checks++;
    if (cyc < 0) begin
      n_fail++;
      $display("FAIL rstdump_done: no done pulse, required one");
    end
  endtask

  task automatic test_arm_trig_same();
    int cyc;
    logic [7:0] e, a;
    samples_i = pack(8'h60);
    do_arm(2'd1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      samples_i = pack(8'h61 + i);
      tick();
    end
    n_checks++;
    if (busy !== 1'b1 || tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL same_armed: busy=%b valid=%b, required 1/0", busy, tx_valid);
    end
    do_capture(1, 8'h01, -1, -1);
    drain(DEP + 2, 1'b0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      if (rx_q.size() > 0) a = rx_q.pop_front(); else a = 'x;
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL same_byte%0d: got %h, required %h", i, a, e);
      end
    end
    tick();
    arm = 1'b1;
    ch_sel = 2'd2;
    tick();
    arm = 1'b0;
    wait_done(cyc);
    n_checks++;
    if (cyc < 0) begin
      n_fail++;
      $display("FAIL hold_arm_done: no done pulse, required one");
    end
    repeat (3) tick();
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_arm_ignored: busy=%b, required 0", busy);
    end
  endtask
`else
  // Pre-trigger window: trig-cycle sample lands at dump index PRE; short arming leaves zeros.
  task automatic test_pretrigger(input int k);
    int cyc;
    int base;
    logic [7:0] e, a;
    base = 8'h20;
    do_arm(2'd2, 1'b0);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h02);
    for (int idx = 0; idx < DEP; idx++) begin
      if (idx < PREN - k) exp_q.push_back(8'h00);
      else exp_q.push_back(8'(base + k - PREN + idx));
    end
    for (int i = 0; i < k; i++) begin
      samples_i = pack(base + i);
      tick();
    end
    for (int i = 0; i < DEP - PREN; i++) begin
      trig = (i == 0);
      samples_i = pack(base + k + i);
      tick();
    end
    trig = 1'b0;
    drain(DEP + 2, 1'b0);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      if (rx_q.size() > 0) a = rx_q.pop_front(); else a = 'x;
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL pre%0d_byte%0d: got %h, required %h", k, i, a, e);
      end
    end
    wait_done(cyc);
    n_checks++;
    if (cyc < 0) begin
      n_fail++;
      $display("FAIL pre%0d_done: no done pulse, required one", k);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef TRACE_PRETRIGGER_EN
    test_pretrigger(6);
    test_pretrigger(2);
`else
    test_basic();
    test_mark();
    test_stall();
    test_reset_mid_dump();
    test_arm_trig_same();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sensor_trace_buffer.md
SENSOR_TRACE_BUFFER -- requirements
Module: sensor_trace_buffer

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of sensor channels.
REQ-002 SHALL have parameter SAMPLE_W, default 8, bits per channel sample, 1..8.
REQ-003 SHALL have parameter DEPTH, default 2048, samples per capture, power of two, 16..4096.
REQ-004 SHALL have parameter PRE, default 512, pre-trigger samples (used only with REQ-030), less than DEPTH.
REQ-005 SHALL have parameter MARK_CODE, default 8'hFF, byte stored in place of a sample while mark is high.
REQ-006 SHALL have parameter HOLDOFF, default 4096, idle cycles after a dump.
REQ-007 SHALL have port clk, input, 1, sole clock; one clock, all logic on its rising edge.
REQ-008 SHALL have port rstn, input, 1, reset; asynchronous, active-low.
REQ-009 SHALL have port samples_i, input, CHANNELS*SAMPLE_W, packed channel samples, channel 0 in the LSBs.
REQ-010 SHALL have port ch_sel, input, clog2(CHANNELS), channel to capture; latched on arm.
REQ-011 SHALL have port arm, input, 1, single-cycle request to arm.
REQ-012 SHALL have port trig, input, 1, capture trigger (the AES start strobe).
REQ-013 SHALL have port mark, input, 1, event flag (the AES done strobe).
REQ-014 SHALL have port tx_data, output, 8, dump byte.
REQ-015 SHALL have port tx_valid, output, 1, tx_data valid.
REQ-016 SHALL have port tx_ready, input, 1, sink accepts the byte.
REQ-017 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-018 SHALL have port done, output, 1, one-cycle pulse when HOLDOFF ends.

Function
REQ-019 SHALL implement states IDLE, ARMED, CAPTURE, DUMP, HOLD.
REQ-020 IDLE: on arm, latch ch_sel and go to ARMED; trig in the same cycle is ignored.
REQ-021 ARMED: on trig, go to CAPTURE; the sample taken in the trig cycle is sample 0.
REQ-022 CAPTURE: write one byte per cycle. Stored byte = MARK_CODE when mark is high, else the selected channel sample zero-extended to 8 bits. After DEPTH writes (PRE+DEPTH-PRE with REQ-030), go to DUMP; trig is ignored.
REQ-023 The write address SHALL be clog2(DEPTH) bits and wrap modulo DEPTH.
REQ-024 DUMP: send 8'hA5, then the latched channel index, then DEPTH samples oldest-first; total DEPTH+2 bytes.
REQ-025 The handshake SHALL transfer a byte on a cycle where tx_valid and tx_ready are both high. tx_data SHALL stay stable while tx_valid is high and tx_ready is low. tx_valid SHALL NOT drop before the transfer. Back-to-back transfers SHALL be supported at one byte per cycle.
REQ-026 RAM read latency of 1 cycle SHALL be hidden by a one-byte prefetch, so the throughput of REQ-025 holds.
REQ-027 HOLD: count HOLDOFF cycles, pulse done, go to IDLE; arm is ignored.
REQ-028 A value of ch_sel at or above CHANNELS SHALL select channel 0.

Reset
REQ-029 On rstn low, in any state: state goes to IDLE; tx_valid, tx_data, busy, done and all counters go to 0; latched channel goes to 0. RAM contents are not cleared. Operation resumes on the first clk edge after rstn is released.

Configuration
REQ-030 With TRACE_PRETRIGGER_EN defined:
- ARMED writes the selected channel circularly every cycle.
- On trig, CAPTURE writes DEPTH-PRE further samples.
- The dump starts at the write pointer minus DEPTH (oldest sample); the trig-cycle sample is at dump index PRE.
- If ARMED lasted fewer than PRE cycles, the unfilled entries dump as 8'h00.
Without the macro: PRE is unused, ARMED does not write, and REQ-022 applies as stated.

Structure
REQ-031 Package sensor_trace_pkg SHALL hold the state enum, HEADER_BYTE=8'hA5 and a clog2-based address-width function.
REQ-032 The sample store SHALL be sub-module trace_ram: simple dual-port, registered read, DEPTH x 8.

Verification
REQ-033 DEPTH=16, tx_ready=1, arm, then trig 3 cycles later with channel 2 ramp 0..15 -> A5,02,00..0F, then done after HOLDOFF.
REQ-034 mark high on capture cycles 4-5 -> dump bytes 6-7 = FF, others unchanged.
REQ-035 tx_ready toggling 1/0 each cycle -> every byte transferred exactly once, tx_data stable while stalled, 18 bytes.
REQ-036 rstn low in mid-DUMP at byte 9 -> outputs 0 asynchronously; a new arm/trig gives a full fresh dump.
REQ-037 TRACE_PRETRIGGER_EN, DEPTH=16, PRE=4, ramp running -> trig-cycle value appears at dump index 4 (output byte 6).
REQ-038 arm and trig in the same IDLE cycle -> ARMED only, no capture until the next trig; arm during HOLD is ignored.
